// File: rtl/regbank_pkg.sv
// Shared types and default sizes for the register bank and its read-side companion.
package regbank_pkg;

   localparam int DEF_BITS = 32;
   localparam int DEF_NUM  = 7;
   localparam int DEF_AW   = $clog2(DEF_NUM + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SINGLE = 2'd1,
      DUMP   = 2'd2
   } state_t;

   typedef struct packed {
      logic [DEF_BITS-1:0] data;
      logic [DEF_AW-1:0]   addr;
      logic                last;
      logic                err;
   } beat_t;

endpackage

// File: rtl/regbank_snapshot.sv
// Capture copy of the whole register bank, loaded in one cycle by a strobe.
module regbank_snapshot
   import regbank_pkg::*;
#(
   parameter int BITS = DEF_BITS,
   parameter int NUM  = DEF_NUM
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            load,
   input  logic [BITS-1:0] d [NUM-1:0],
   output logic [BITS-1:0] q [NUM-1:0]
);

   logic [BITS-1:0] cap_reg [NUM-1:0];

   generate
      for (genvar gi = 0; gi < NUM; gi++) begin : g_cap
         always_ff @(posedge clk) begin
            if (!reset_n)
               cap_reg[gi] <= '0;
            else if (load)
               cap_reg[gi] <= d[gi];
         end
         assign q[gi] = cap_reg[gi];
      end
   endgenerate

endmodule

// File: rtl/regbank_reader.sv
// Read-side server for the register bank: single reads and burst dumps over
// valid/ready request/response channels, optionally from an atomic snapshot.
module regbank_reader
   import regbank_pkg::*;
#(
   parameter int BITS     = DEF_BITS,
   parameter int NUM      = DEF_NUM,
   parameter int AW       = $clog2(NUM + 1),
   parameter int SNAPSHOT = 0
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [BITS-1:0] q_in [NUM-1:0],
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [AW-1:0]   req_addr,
   input  logic            req_dump,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [BITS-1:0] rsp_data,
   output logic [AW-1:0]   rsp_addr,
   output logic            rsp_last,
   output logic            rsp_err,
   output logic            busy
);

   state_t          state_reg;
   logic [BITS-1:0] data_reg;
   logic [AW-1:0]   addr_reg;
   logic            valid_reg;
   logic            last_reg;
   logic            err_reg;

   logic [BITS-1:0] src [NUM-1:0];
   logic [BITS-1:0] acc_data;
   logic [BITS-1:0] next_data;
   logic [AW-1:0]   addr_next;
   logic            accept;
   logic            in_range;

   assign accept    = req_valid && (state_reg == IDLE);
   assign in_range  = req_addr < AW'(NUM);
   assign addr_next = addr_reg + AW'(1);

   // Later dump beats read either the frozen copy or the live bank.
   generate
      if (SNAPSHOT != 0) begin : g_snap
         logic [BITS-1:0] snap_q [NUM-1:0];

         regbank_snapshot #(
            .BITS (BITS),
            .NUM  (NUM)
         ) u_snapshot (
            .clk     (clk),
            .reset_n (reset_n),
            .load    (accept),
            .d       (q_in),
            .q       (snap_q)
         );

         for (genvar gi = 0; gi < NUM; gi++) begin : g_src
            assign src[gi] = snap_q[gi];
         end
      end else begin : g_live
         for (genvar gi = 0; gi < NUM; gi++) begin : g_src
            assign src[gi] = q_in[gi];
         end
      end
   endgenerate

   always_comb begin
      acc_data  = '0;
      next_data = '0;
      for (int i = 0; i < NUM; i++) begin
         if (req_addr == AW'(i))
            acc_data = q_in[i];
         if (addr_next == AW'(i))
            next_data = src[i];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg <= IDLE;
         valid_reg <= 1'b0;
         data_reg  <= '0;
         addr_reg  <= '0;
         last_reg  <= 1'b0;
         err_reg   <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (req_valid) begin
                  valid_reg <= 1'b1;
                  addr_reg  <= req_addr;
                  if (!in_range) begin
                     data_reg  <= '0;
                     last_reg  <= 1'b1;
                     err_reg   <= 1'b1;
                     state_reg <= SINGLE;
                  end else if (!req_dump) begin
                     data_reg  <= acc_data;
                     last_reg  <= 1'b1;
                     err_reg   <= 1'b0;
                     state_reg <= SINGLE;
                  end else begin
                     data_reg  <= acc_data;
                     last_reg  <= (req_addr == AW'(NUM - 1));
                     err_reg   <= 1'b0;
                     state_reg <= DUMP;
                  end
               end
            end
            SINGLE: begin
               if (rsp_ready) begin
                  valid_reg <= 1'b0;
                  last_reg  <= 1'b0;
                  err_reg   <= 1'b0;
                  state_reg <= IDLE;
               end
            end
            DUMP: begin
               if (rsp_ready) begin
                  if (last_reg) begin
                     valid_reg <= 1'b0;
                     last_reg  <= 1'b0;
                     state_reg <= IDLE;
                  end else begin
                     addr_reg <= addr_next;
                     data_reg <= next_data;
                     last_reg <= (addr_next == AW'(NUM - 1));
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign req_ready = (state_reg == IDLE);
   assign busy      = (state_reg != IDLE);
   assign rsp_valid = valid_reg;
   assign rsp_data  = data_reg;
   assign rsp_addr  = addr_reg;
   assign rsp_last  = last_reg;
   assign rsp_err   = err_reg;

endmodule
